lamp_control: RTL and testbench

//  Three-way lamp control: any one of three wall switches S1..S3 toggles the lamp.

---
 rtl/lamp_control.sv | 125 ++++++++++++
 tb/tb_lamp_control.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/lamp_control.sv
// ---------------------------------------------------------------------------
// lamp_control
//   Three-way lamp control. Each raw wall switch is synchronised into the clk
//   domain, then debounced: a new level is accepted only after it has been
//   seen for DEBOUNCE_CYCLES consecutive cycles. The lamp drive F is the
//   registered odd parity of the three accepted levels.
//
// Ports
//   clk      in   1      system clock, rising edge
//   rst_n    in   1      asynchronous active-low reset
//   S1..S3   in   1      raw switch levels (asynchronous, may bounce)
//   F        out  1      lamp drive, 1 = on (registered)
//   TOGGLES  out  CNT_W  lamp toggle count, present only when the macro
//                        LAMPCTRL_TOGGLE_CNT_EN is defined
//
// Parameters
//   SYNC_STAGES      synchroniser depth (>= 2)
//   DEBOUNCE_CYCLES  stable cycles needed to accept a level (>= 1)
//   CNT_W            toggle counter width
// ---------------------------------------------------------------------------
module lamp_control #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             S1,
    input  logic             S2,
    input  logic             S3,
    output logic             F
`ifdef LAMPCTRL_TOGGLE_CNT_EN
    ,
    output logic [CNT_W-1:0] TOGGLES
`endif
);

    localparam int unsigned     DC_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DC_W-1:0] DC_LAST = DC_W'(DEBOUNCE_CYCLES - 1);

    if (SYNC_STAGES < 2)     begin : g_bad_sync  $error("SYNC_STAGES must be >= 2");     end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb   $error("DEBOUNCE_CYCLES must be >= 1"); end
    if (CNT_W < 1)           begin : g_bad_cnt   $error("CNT_W must be >= 1");           end

    // Each synchroniser stage carries all three switches side by side.
    logic [2:0]      sync_q [SYNC_STAGES];
    logic [2:0]      sync_d [SYNC_STAGES];
    logic [2:0]      sw_s;
    logic [2:0]      deb_q, deb_d;
    logic [DC_W-1:0] cnt_q [3];
    logic [DC_W-1:0] cnt_d [3];
    logic            f_q, f_d;

    assign sw_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d[0] = {S3, S2, S1};
        for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end

        deb_d = deb_q;
        for (int unsigned i = 0; i < 3; i++) begin
            // Counter idles at 0 while synced level matches accepted level;
            // any bounce back therefore discards the partial count.
            cnt_d[i] = '0;
            if (sw_s[i] != deb_q[i]) begin
                if (cnt_q[i] == DC_LAST) begin
                    deb_d[i] = sw_s[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + DC_W'(1);
                end
            end
        end

        f_d = ^deb_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            for (int unsigned i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
            deb_q <= '0;
            f_q   <= 1'b0;
        end else begin
            for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
            for (int unsigned i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            deb_q <= deb_d;
            f_q   <= f_d;
        end
    end

    assign F = f_q;

`ifdef LAMPCTRL_TOGGLE_CNT_EN
    logic [CNT_W-1:0] toggles_q, toggles_d;

    // Counts edges of F: bumps on the cycle F is about to change; wraps naturally.
    always_comb begin
        toggles_d = toggles_q;
        if (f_d != f_q) begin
            toggles_d = toggles_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            toggles_q <= '0;
        end else begin
            toggles_q <= toggles_d;
        end
    end

    assign TOGGLES = toggles_q;
`endif

endmodule

// File: tb/tb_lamp_control.sv
module tb_lamp_control;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int CW   = 2;
    localparam int LAT  = SYNC + DEB + 1;

    logic clk;
    logic rst_n;
    logic S1, S2, S3;
    logic F;
`ifdef LAMPCTRL_TOGGLE_CNT_EN
    logic [CW-1:0] TOGGLES;
`endif

    int n_pass;
    int n_total;

    lamp_control #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (CW)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .S1     (S1),
        .S2     (S2),
        .S3     (S3),
        .F      (F)
`ifdef LAMPCTRL_TOGGLE_CNT_EN
        ,
        .TOGGLES(TOGGLES)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: raw switch samples per clock edge, newest first.
    // A level is accepted when the last DEB synchronised samples (raw
    // samples delayed SYNC edges) all disagree with the accepted level.
    logic [2:0] hist [SYNC+DEB];
    logic [2:0] m_d;
    logic       m_f;
    logic       m_nf;
    logic       m_acc;
    int         m_tog;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC + DEB; k++) hist[k] = 3'b000;
            m_d   = 3'b000;
            m_f   = 1'b0;
            m_tog = 0;
        end else begin
            m_nf = ^m_d;
            if (m_nf != m_f) m_tog = (m_tog + 1) % (1 << CW);
            m_f = m_nf;
            for (int k = SYNC + DEB - 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = {S3, S2, S1};
            for (int i = 0; i < 3; i++) begin
                m_acc = 1'b1;
                for (int j = SYNC; j < SYNC + DEB; j++) begin
                    if (hist[j][i] == m_d[i]) m_acc = 1'b0;
                end
                if (m_acc) m_d[i] = ~m_d[i];
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        n_total++;
        if (F === m_f) n_pass++;
        else $display("FAIL model_F t=%0t actual=%0b expected=%0b", $time, F, m_f);
`ifdef LAMPCTRL_TOGGLE_CNT_EN
        n_total++;
        if (TOGGLES === CW'(m_tog)) n_pass++;
        else $display("FAIL model_TOGGLES t=%0t actual=%0d expected=%0d", $time, TOGGLES, m_tog);
`endif
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s t=%0t actual=%0d expected=%0d", name, $time, act, exp);
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic [2:0] v);
        @(negedge clk);
        {S3, S2, S1} = v;
    endtask

    task automatic reset_pulse(input int cycles);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("reset_async_F", 32'(F), 32'd0);
        wait_neg(cycles);
        #2 rst_n = 1'b1;
    endtask

    logic [7:0] walk_f;

    initial begin
        n_pass  = 0;
        n_total = 0;
        walk_f  = 8'b1001_0110;   // bit v = expected F for S3S2S1 = v
        rst_n   = 1'b0;
        {S3, S2, S1} = 3'b000;

        // 1: reset and idle
        wait_neg(3);
        #2 rst_n = 1'b1;
        wait_neg(20);
        chk("idle_F", 32'(F), 32'd0);
`ifdef LAMPCTRL_TOGGLE_CNT_EN
        chk("idle_TOGGLES", 32'(TOGGLES), 32'd0);
`endif

        // 2: truth-table walk with exact latency
        for (int v = 0; v < 8; v++) begin
            drive(3'(v));
            wait_neg(LAT - 1);
            chk("walk_before", 32'(F), 32'(walk_f[(v == 0) ? 0 : v - 1]));
            wait_neg(1);
            chk("walk_after", 32'(F), 32'(walk_f[v]));
            wait_neg(50 - LAT);
        end

        // 3: short glitch on S1 is rejected
        drive(3'b000);
        wait_neg(50);
        chk("pre_glitch_F", 32'(F), 32'd0);
        drive(3'b001);
        wait_neg(2);
        drive(3'b000);
        wait_neg(20);
        chk("glitch_F", 32'(F), 32'd0);

        // 4: S1 and S2 accepted together, parity unchanged
        drive(3'b011);
        wait_neg(LAT);
        chk("dual_F_lat", 32'(F), 32'd0);
        wait_neg(40);
        chk("dual_F_late", 32'(F), 32'd0);

        // 5: reset clears F asynchronously; held S1 is re-accepted
        drive(3'b001);
        wait_neg(20);
        chk("s1_on_F", 32'(F), 32'd1);
        reset_pulse(2);
        wait_neg(LAT - 1);
        chk("rearm_before", 32'(F), 32'd0);
        wait_neg(1);
        chk("rearm_after", 32'(F), 32'd1);
        drive(3'b000);
        wait_neg(20);
        drive(3'b001);
        wait_neg(4);          // debounce in progress
        reset_pulse(2);
        wait_neg(LAT - 1);
        chk("middeb_before", 32'(F), 32'd0);
        wait_neg(1);
        chk("middeb_after", 32'(F), 32'd1);

        // 6: five toggles wrap a 2-bit counter to 1
        drive(3'b000);
        reset_pulse(2);
        wait_neg(20);
        for (int t = 0; t < 5; t++) begin
            drive((t % 2 == 0) ? 3'b001 : 3'b000);
            wait_neg(20);
        end
        chk("wrap_F", 32'(F), 32'd1);
`ifdef LAMPCTRL_TOGGLE_CNT_EN
        chk("wrap_TOGGLES", 32'(TOGGLES), 32'd1);
`endif

        wait_neg(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
